icache_direct: RTL

- Direct-mapped instruction cache between the instruction-fetch unit (upstream) and the memory controller (downstream).
- Serves one 32-bit instruction per fetch request.
- On a miss, requests one aligned 2-instruction block from the memory controller, fills the line, then answers the fetch.
- Supports a fetch-abort (clear) for branch misprediction.

---
 rtl/icache_direct.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: 1-cycle hits, one block read per miss, mispredict abort.
// Optional next-line prefetch is compiled in with ICACHE_PREFETCH_EN.
module icache_direct #(
    parameter int BLOCK_WIDTH = 1,
    parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH,
    parameter int CACHE_WIDTH = 8,
    parameter int BLOCK_NUM   = 1 << CACHE_WIDTH,
    parameter int ADDR_WIDTH  = 32,
    parameter int TAG_WIDTH   = ADDR_WIDTH - CACHE_WIDTH - BLOCK_WIDTH - 2
) (
    input  logic                     Sys_clk,
    input  logic                     Sys_rst,
    input  logic                     Sys_rdy,
    input  logic                     IFIC_en,
    input  logic [ADDR_WIDTH-1:0]    IFIC_addr,
    input  logic                     IFIC_clr,
    output logic                     ICIF_en,
    output logic [31:0]              ICIF_inst,
    output logic                     ICMC_en,
    output logic [ADDR_WIDTH-1:0]    ICMC_addr,
    input  logic                     MCIC_en,
    input  logic [32*BLOCK_SIZE-1:0] MCIC_block
);
    localparam int IDX_LSB = BLOCK_WIDTH + 2;
    localparam int TAG_LSB = CACHE_WIDTH + BLOCK_WIDTH + 2;

`ifdef ICACHE_PREFETCH_EN
    typedef enum logic [1:0] {S_IDLE, S_MISS, S_PREFETCH} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_MISS} state_t;
`endif

    state_t                  state_q, state_d;
    logic                    drop_q, drop_d;
    logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic                    icif_en_q, icif_en_d;
    logic [31:0]             icif_inst_q, icif_inst_d;
    logic                    icmc_en_q, icmc_en_d;
    logic [ADDR_WIDTH-1:0]   icmc_addr_q, icmc_addr_d;
    logic [BLOCK_NUM-1:0]    valid_q, valid_d;

    logic [TAG_WIDTH-1:0]    tag_mem  [BLOCK_NUM];
    logic [32*BLOCK_SIZE-1:0] data_mem [BLOCK_NUM];

    logic                    fill_we;
    logic [CACHE_WIDTH-1:0]  fill_idx;
    logic [TAG_WIDTH-1:0]    fill_tag;

    logic [CACHE_WIDTH-1:0]  in_idx;
    logic [TAG_WIDTH-1:0]    in_tag;
    logic [BLOCK_WIDTH-1:0]  in_off, req_off;
    logic                    hit, accept;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^IFIC_addr[1:0];

    function automatic logic [31:0] word_of(input logic [32*BLOCK_SIZE-1:0] blk,
                                            input logic [BLOCK_WIDTH-1:0] off);
        return blk[32*off +: 32];
    endfunction

    assign in_idx   = IFIC_addr[TAG_LSB-1:IDX_LSB];
    assign in_tag   = IFIC_addr[ADDR_WIDTH-1:TAG_LSB];
    assign in_off   = IFIC_addr[IDX_LSB-1:2];
    assign req_off  = req_addr_q[IDX_LSB-1:2];
    assign fill_idx = req_addr_q[TAG_LSB-1:IDX_LSB];
    assign fill_tag = req_addr_q[ADDR_WIDTH-1:TAG_LSB];
    assign hit      = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);
    // No accept in the response-pulse cycle: IF is allowed to move its PC then.
    assign accept   = IFIC_en && !icif_en_q && !IFIC_clr;

`ifdef ICACHE_PREFETCH_EN
    logic [ADDR_WIDTH-1:0]  nxt_addr;
    logic [CACHE_WIDTH-1:0] nxt_idx;
    logic [TAG_WIDTH-1:0]   nxt_tag;
    logic                   pf_match;
    assign nxt_addr = icmc_addr_q + ADDR_WIDTH'(BLOCK_SIZE * 4);
    assign nxt_idx  = nxt_addr[TAG_LSB-1:IDX_LSB];
    assign nxt_tag  = nxt_addr[ADDR_WIDTH-1:TAG_LSB];
    assign pf_match = IFIC_addr[ADDR_WIDTH-1:IDX_LSB] == req_addr_q[ADDR_WIDTH-1:IDX_LSB];
`endif

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        req_addr_d  = req_addr_q;
        icif_en_d   = 1'b0;
        icif_inst_d = icif_inst_q;
        icmc_en_d   = icmc_en_q;
        icmc_addr_d = icmc_addr_q;
        valid_d     = valid_q;
        fill_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (hit) begin
                        icif_en_d   = 1'b1;
                        icif_inst_d = word_of(data_mem[in_idx], in_off);
                    end else begin
                        req_addr_d  = IFIC_addr;
                        icmc_en_d   = 1'b1;
                        icmc_addr_d = {IFIC_addr[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
                        state_d     = S_MISS;
                    end
                end
            end
            S_MISS: begin
                if (IFIC_clr) drop_d = 1'b1;
                if (MCIC_en) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    icmc_en_d         = 1'b0;
                    drop_d            = 1'b0;
                    state_d           = S_IDLE;
                    if (!drop_q && !IFIC_clr) begin
                        icif_en_d   = 1'b1;
                        icif_inst_d = word_of(MCIC_block, req_off);
                    end
`ifdef ICACHE_PREFETCH_EN
                    if (!(valid_q[nxt_idx] && tag_mem[nxt_idx] == nxt_tag)) begin
                        icmc_en_d   = 1'b1;
                        icmc_addr_d = nxt_addr;
                        req_addr_d  = nxt_addr;
                        state_d     = S_PREFETCH;
                    end
`endif
                end
            end
`ifdef ICACHE_PREFETCH_EN
            S_PREFETCH: begin
                // Demand fetches stall here; one that targets this block is served from the fill.
                if (MCIC_en) begin
                    fill_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    icmc_en_d         = 1'b0;
                    state_d           = S_IDLE;
                    if (accept && pf_match) begin
                        icif_en_d   = 1'b1;
                        icif_inst_d = word_of(MCIC_block, in_off);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            state_q     <= S_IDLE;
            drop_q      <= 1'b0;
            req_addr_q  <= '0;
            icif_en_q   <= 1'b0;
            icif_inst_q <= '0;
            icmc_en_q   <= 1'b0;
            icmc_addr_q <= '0;
            valid_q     <= '0;
        end else if (Sys_rdy) begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            req_addr_q  <= req_addr_d;
            icif_en_q   <= icif_en_d;
            icif_inst_q <= icif_inst_d;
            icmc_en_q   <= icmc_en_d;
            icmc_addr_q <= icmc_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Tag/data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge Sys_clk) begin
        if (!Sys_rst && Sys_rdy && fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= MCIC_block;
        end
    end

    assign ICIF_en   = icif_en_q;
    assign ICIF_inst = icif_inst_q;
    assign ICMC_en   = icmc_en_q;
    assign ICMC_addr = icmc_addr_q;
endmodule
